systolic_feed_controller: RTL and testbench

//  Sequences one activation stream from the unified buffer (UB) into the systolic_data_staging skew block.

---
 rtl/systolic_feed_controller.sv | 145 ++++++++++++++
 tb/tb_systolic_feed_controller.sv | 233 +++++++++++++++++++++++
 2 files changed

// File: rtl/systolic_feed_controller.sv
`timescale 1ns/1ps
// systolic_feed_controller: streams N unified-buffer rows into the skew staging block,
// then waits for the last lane of the last row to leave the skew before pulsing done_o.
module systolic_feed_controller #(
   parameter int unsigned DIM       = 32,
   parameter int unsigned ADDR_W    = 16,
   parameter int unsigned LEN_W     = 16,
   parameter int unsigned UB_RD_LAT = 1
) (
   input  logic              clk_i,
   input  logic              rst_n_i,
   input  logic              start_i,
   input  logic [ADDR_W-1:0] base_addr_i,
   input  logic [LEN_W-1:0]  num_rows_i,
   input  logic              weights_rdy_i,
   output logic              busy_o,
   output logic              done_o,
   output logic              ub_rd_en_o,
   output logic [ADDR_W-1:0] ub_rd_addr_o,
   output logic              stage_read_o,
   output logic [DIM-1:0]    act_valid_o
);

   // Drain covers the UB latency plus the skew of the slowest lane.
   localparam int unsigned DrainInit = UB_RD_LAT + DIM - 1;
   localparam int unsigned CntW      = $clog2(DrainInit + 1);

   typedef enum logic [2:0] {
      StIdle,
      StWaitW,
      StFetch,
      StDrain,
      StDone
   } state_e;

   state_e              state_q, state_d;
   logic [ADDR_W-1:0]   base_q, base_d;
   logic [LEN_W-1:0]    num_q, num_d;
   logic [LEN_W-1:0]    row_q, row_d;
   logic [ADDR_W-1:0]   addr_q, addr_d;
   logic [CntW-1:0]     drain_q, drain_d;
   logic [UB_RD_LAT-1:0] rd_pipe_q, rd_pipe_d;
   // lane_q[j] holds the valid for skew lane j+1; lane 0 is stage_read_o itself.
   logic [DIM-2:0]      lane_q, lane_d;

   // Job sequencing: capture, weights wait, contiguous fetch, drain countdown, done pulse.
   always_comb begin
      state_d = state_q;
      base_d  = base_q;
      num_d   = num_q;
      row_d   = row_q;
      addr_d  = addr_q;
      drain_d = drain_q;
      unique case (state_q)
         StIdle: begin
            if (start_i) begin
               base_d  = base_addr_i;
               num_d   = num_rows_i;
               state_d = (num_rows_i == '0) ? StDone : StWaitW;
            end
         end
         StWaitW: begin
            if (weights_rdy_i) begin
               state_d = StFetch;
               row_d   = '0;
               addr_d  = base_q;
            end
         end
         StFetch: begin
            if (row_q == num_q - LEN_W'(1)) begin
               // Address is left on the last row read.
               state_d = StDrain;
               drain_d = CntW'(DrainInit);
            end else begin
               row_d  = row_q + LEN_W'(1);
               addr_d = addr_q + ADDR_W'(1);
            end
         end
         StDrain: begin
            if (drain_q == CntW'(1)) begin
               state_d = StDone;
            end else begin
               drain_d = drain_q - CntW'(1);
            end
         end
         StDone: begin
            state_d = StIdle;
         end
         default: begin
            state_d = StIdle;
         end
      endcase
   end

   // State-decoded outputs.
   always_comb begin
      busy_o       = (state_q != StIdle);
      done_o       = (state_q == StDone);
      ub_rd_en_o   = (state_q == StFetch);
      ub_rd_addr_o = addr_q;
   end

   // Delay pipes: UB latency onto the staging strobe, then one cycle per skew lane.
   always_comb begin
      rd_pipe_d    = '0;
      lane_d       = '0;
      rd_pipe_d[0] = ub_rd_en_o;
      for (int i = 1; i < UB_RD_LAT; i++) begin
         rd_pipe_d[i] = rd_pipe_q[i-1];
      end
      lane_d[0] = rd_pipe_q[UB_RD_LAT-1];
      for (int k = 1; k < DIM - 1; k++) begin
         lane_d[k] = lane_q[k-1];
      end
   end

   always_comb begin
      stage_read_o = rd_pipe_q[UB_RD_LAT-1];
      act_valid_o  = {lane_q, stage_read_o};
   end

   // State and pipe registers; reset also flushes in-flight strobes so an aborted job is silent.
   always_ff @(posedge clk_i) begin
      if (!rst_n_i) begin
         state_q   <= StIdle;
         base_q    <= '0;
         num_q     <= '0;
         row_q     <= '0;
         addr_q    <= '0;
         drain_q   <= '0;
         rd_pipe_q <= '0;
         lane_q    <= '0;
      end else begin
         state_q   <= state_d;
         base_q    <= base_d;
         num_q     <= num_d;
         row_q     <= row_d;
         addr_q    <= addr_d;
         drain_q   <= drain_d;
         rd_pipe_q <= rd_pipe_d;
         lane_q    <= lane_d;
      end
   end

endmodule

// File: tb/tb_systolic_feed_controller.sv
`timescale 1ns/1ps
// Directed bench for systolic_feed_controller (DIM=32, UB_RD_LAT=1).
// Cycle index i=0 is the cycle right after start_i was accepted; with weights ready the
// first FETCH cycle is i=1, so done_o lands at i = 1 + N + 1 + 31.
module tb_systolic_feed_controller;

   logic        clk = 1'b0;
   logic        rst_n;
   logic        start;
   logic [15:0] base;
   logic [15:0] num;
   logic        rdy;
   logic        busy, done, en, sr;
   logic [15:0] addr;
   logic [31:0] av;

   int tests = 0;
   int fails = 0;

   logic        en_a   [64];
   logic        sr_a   [64];
   logic        done_a [64];
   logic        busy_a [64];
   logic [15:0] addr_a [64];
   logic [31:0] av_a   [64];

   always #5 clk = ~clk;

   systolic_feed_controller #(
      .DIM      (32),
      .ADDR_W   (16),
      .LEN_W    (16),
      .UB_RD_LAT(1)
   ) dut (
      .clk_i        (clk),
      .rst_n_i      (rst_n),
      .start_i      (start),
      .base_addr_i  (base),
      .num_rows_i   (num),
      .weights_rdy_i(rdy),
      .busy_o       (busy),
      .done_o       (done),
      .ub_rd_en_o   (en),
      .ub_rd_addr_o (addr),
      .stage_read_o (sr),
      .act_valid_o  (av)
   );

   task automatic step();
      @(posedge clk);
      #1;
   endtask

   // Present a job for one edge; on return we are in cycle i=0.
   task automatic launch(input logic [15:0] b, input logic [15:0] n, input logic r);
      start = 1'b1;
      base  = b;
      num   = n;
      rdy   = r;
      step();
      start = 1'b0;
   endtask

   // Record n cycles of outputs; optionally pulse start_i (with base pb, num pn) at cycle pulse_at.
   task automatic capture(input int n, input int pulse_at, input logic [15:0] pb,
                          input logic [15:0] pn);
      for (int i = 0; i < n; i++) begin
         en_a[i]   = en;
         sr_a[i]   = sr;
         done_a[i] = done;
         busy_a[i] = busy;
         addr_a[i] = addr;
         av_a[i]   = av;
         if (i == pulse_at) begin
            start = 1'b1;
            base  = pb;
            num   = pn;
         end else begin
            start = 1'b0;
         end
         step();
      end
      start = 1'b0;
   endtask

   task automatic test_reset();
      rst_n = 1'b0;
      start = 1'b0;
      base  = 16'h0;
      num   = 16'h0;
      rdy   = 1'b0;
      step();
      step();
      for (int r = 0; r < 2; r++) begin
         tests++; if (busy !== 1'b0) begin fails++; $display("FAIL reset_busy got %b want 0", busy); end
         tests++; if (done !== 1'b0) begin fails++; $display("FAIL reset_done got %b want 0", done); end
         tests++; if (en !== 1'b0) begin fails++; $display("FAIL reset_en got %b want 0", en); end
         tests++; if (addr !== 16'h0) begin fails++; $display("FAIL reset_addr got %h want 0", addr); end
         tests++; if (sr !== 1'b0) begin fails++; $display("FAIL reset_sr got %b want 0", sr); end
         tests++; if (av !== 32'h0) begin fails++; $display("FAIL reset_av got %h want 0", av); end
         rst_n = 1'b1;
         step();
      end
   endtask

   // N=4 from 0x0010: reads i=1..4, strobe i=2..5, lane k valid i=2+k..5+k, done at i=37.
   task automatic test_basic();
      logic [31:0] exp_av;
      logic        exp_en, exp_sr;
      launch(16'h0010, 16'd4, 1'b1);
      capture(40, -1, 16'h0, 16'h0);
      for (int i = 0; i < 40; i++) begin
         exp_en = (i >= 1 && i <= 4);
         exp_sr = (i >= 2 && i <= 5);
         exp_av = '0;
         for (int k = 0; k < 32; k++) exp_av[k] = (i >= k + 2 && i <= k + 5);
         tests++; if (en_a[i] !== exp_en) begin fails++; $display("FAIL basic_en i=%0d got %b want %b", i, en_a[i], exp_en); end
         tests++; if (sr_a[i] !== exp_sr) begin fails++; $display("FAIL basic_sr i=%0d got %b want %b", i, sr_a[i], exp_sr); end
         tests++; if (av_a[i] !== exp_av) begin fails++; $display("FAIL basic_av i=%0d got %h want %h", i, av_a[i], exp_av); end
         tests++; if (done_a[i] !== (i == 37)) begin fails++; $display("FAIL basic_done i=%0d got %b", i, done_a[i]); end
         tests++; if (busy_a[i] !== (i <= 37)) begin fails++; $display("FAIL basic_busy i=%0d got %b", i, busy_a[i]); end
         if (i >= 1) begin
            tests++;
            if (addr_a[i] !== (exp_en ? 16'h0010 + 16'(i - 1) : 16'h0013)) begin
               fails++; $display("FAIL basic_addr i=%0d got %h", i, addr_a[i]);
            end
         end
      end
      // Spot lanes 0, 1, 31 against the strobe window 2..5 shifted by k.
      tests++; if (av_a[2][0] !== 1'b1 || av_a[6][0] !== 1'b0) begin fails++; $display("FAIL lane0 got %b%b want 10", av_a[2][0], av_a[6][0]); end
      tests++; if (av_a[3][1] !== 1'b1 || av_a[2][1] !== 1'b0 || av_a[7][1] !== 1'b0) begin fails++; $display("FAIL lane1 edges wrong"); end
      tests++; if (av_a[33][31] !== 1'b1 || av_a[36][31] !== 1'b1 || av_a[37][31] !== 1'b0) begin fails++; $display("FAIL lane31 edges wrong"); end
   endtask

   // weights_rdy held low 10 cycles: no reads; reads start the cycle after it rises.
   task automatic test_weights_wait();
      launch(16'h0040, 16'd2, 1'b0);
      for (int j = 0; j < 10; j++) begin
         tests++; if (en !== 1'b0) begin fails++; $display("FAIL wait_en j=%0d got %b want 0", j, en); end
         tests++; if (busy !== 1'b1) begin fails++; $display("FAIL wait_busy j=%0d got %b want 1", j, busy); end
         step();
      end
      rdy = 1'b1;
      tests++; if (en !== 1'b0) begin fails++; $display("FAIL wait_en_rise got %b want 0", en); end
      step();
      // j=0 is first FETCH; done expected at 2 + 1 + 31 = 34.
      capture(40, -1, 16'h0, 16'h0);
      tests++; if (en_a[0] !== 1'b1 || addr_a[0] !== 16'h0040) begin fails++; $display("FAIL wait_rd0 got %b/%h want 1/0040", en_a[0], addr_a[0]); end
      tests++; if (en_a[1] !== 1'b1 || addr_a[1] !== 16'h0041) begin fails++; $display("FAIL wait_rd1 got %b/%h want 1/0041", en_a[1], addr_a[1]); end
      tests++; if (en_a[2] !== 1'b0) begin fails++; $display("FAIL wait_rd2 got %b want 0", en_a[2]); end
      for (int j = 0; j < 40; j++) begin
         tests++; if (done_a[j] !== (j == 34)) begin fails++; $display("FAIL wait_done j=%0d got %b", j, done_a[j]); end
      end
      tests++; if (busy_a[35] !== 1'b0) begin fails++; $display("FAIL wait_idle got %b want 0", busy_a[35]); end
   endtask

   // Address wraps past 0xFFFF; done at 1 + 3 + 32 = 36.
   task automatic test_wrap();
      launch(16'hFFFE, 16'd3, 1'b1);
      capture(40, -1, 16'h0, 16'h0);
      tests++; if (addr_a[1] !== 16'hFFFE || en_a[1] !== 1'b1) begin fails++; $display("FAIL wrap_a0 got %h want FFFE", addr_a[1]); end
      tests++; if (addr_a[2] !== 16'hFFFF || en_a[2] !== 1'b1) begin fails++; $display("FAIL wrap_a1 got %h want FFFF", addr_a[2]); end
      tests++; if (addr_a[3] !== 16'h0000 || en_a[3] !== 1'b1) begin fails++; $display("FAIL wrap_a2 got %h want 0000", addr_a[3]); end
      tests++; if (en_a[4] !== 1'b0 || addr_a[4] !== 16'h0000) begin fails++; $display("FAIL wrap_hold got %b/%h want 0/0000", en_a[4], addr_a[4]); end
      tests++; if (done_a[36] !== 1'b1 || done_a[35] !== 1'b0) begin fails++; $display("FAIL wrap_done got %b%b want 01", done_a[35], done_a[36]); end
   endtask

   // N=0: straight to DONE with no weights wait; a second N=0 start in the IDLE cycle is taken.
   task automatic test_zero_len();
      launch(16'h1234, 16'd0, 1'b0);
      capture(6, 1, 16'h0055, 16'd0);
      for (int i = 0; i < 6; i++) begin
         tests++; if (done_a[i] !== (i == 0 || i == 2)) begin fails++; $display("FAIL zero_done i=%0d got %b", i, done_a[i]); end
         tests++; if (busy_a[i] !== (i == 0 || i == 2)) begin fails++; $display("FAIL zero_busy i=%0d got %b", i, busy_a[i]); end
         tests++; if (en_a[i] !== 1'b0 || sr_a[i] !== 1'b0) begin fails++; $display("FAIL zero_rd i=%0d got %b/%b want 0/0", i, en_a[i], sr_a[i]); end
      end
      rdy = 1'b1;
   endtask

   // start_i during FETCH (t=2) must not disturb the running N=6 job; done at 1 + 6 + 32 = 39.
   task automatic test_start_ignored();
      launch(16'h0100, 16'd6, 1'b1);
      capture(46, 3, 16'h0999, 16'd1);
      for (int i = 0; i < 46; i++) begin
         tests++; if (en_a[i] !== (i >= 1 && i <= 6)) begin fails++; $display("FAIL ign_en i=%0d got %b", i, en_a[i]); end
         if (i >= 1 && i <= 6) begin
            tests++; if (addr_a[i] !== 16'h0100 + 16'(i - 1)) begin fails++; $display("FAIL ign_addr i=%0d got %h", i, addr_a[i]); end
         end
         tests++; if (done_a[i] !== (i == 39)) begin fails++; $display("FAIL ign_done i=%0d got %b", i, done_a[i]); end
         tests++; if (busy_a[i] !== (i <= 39)) begin fails++; $display("FAIL ign_busy i=%0d got %b", i, busy_a[i]); end
      end
   endtask

   // One-cycle reset at FETCH t=3 of an N=8 job aborts silently; the next job runs clean.
   task automatic test_reset_mid();
      launch(16'h0200, 16'd8, 1'b1);
      for (int j = 0; j < 4; j++) step();
      tests++; if (en !== 1'b1 || addr !== 16'h0203) begin fails++; $display("FAIL mid_pre got %b/%h want 1/0203", en, addr); end
      rst_n = 1'b0;
      step();
      rst_n = 1'b1;
      tests++; if (busy !== 1'b0 || done !== 1'b0 || en !== 1'b0) begin fails++; $display("FAIL mid_ctl got %b%b%b want 000", busy, done, en); end
      tests++; if (addr !== 16'h0 || sr !== 1'b0 || av !== 32'h0) begin fails++; $display("FAIL mid_data got %h/%b/%h want 0", addr, sr, av); end
      capture(45, -1, 16'h0, 16'h0);
      for (int i = 0; i < 45; i++) begin
         tests++;
         if (done_a[i] !== 1'b0 || busy_a[i] !== 1'b0 || en_a[i] !== 1'b0 || sr_a[i] !== 1'b0 || av_a[i] !== 32'h0) begin
            fails++; $display("FAIL mid_quiet i=%0d got done=%b busy=%b en=%b sr=%b av=%h want all 0", i, done_a[i], busy_a[i], en_a[i], sr_a[i], av_a[i]);
         end
      end
      // Clean N=2 job: reads i=1,2, done at 1 + 2 + 32 = 35.
      launch(16'h0300, 16'd2, 1'b1);
      capture(40, -1, 16'h0, 16'h0);
      tests++; if (addr_a[1] !== 16'h0300 || addr_a[2] !== 16'h0301) begin fails++; $display("FAIL mid_new_addr got %h,%h want 0300,0301", addr_a[1], addr_a[2]); end
      tests++; if (en_a[1] !== 1'b1 || en_a[2] !== 1'b1 || en_a[3] !== 1'b0) begin fails++; $display("FAIL mid_new_en got %b%b%b want 110", en_a[1], en_a[2], en_a[3]); end
      for (int i = 0; i < 40; i++) begin
         tests++; if (done_a[i] !== (i == 35)) begin fails++; $display("FAIL mid_new_done i=%0d got %b", i, done_a[i]); end
      end
   endtask

   initial begin
      test_reset();
      test_basic();
      test_weights_wait();
      test_wrap();
      test_zero_len();
      test_start_ignored();
      test_reset_mid();
      $display("[TB] %0d tests run, %0d failed", tests, fails);
      $finish;
   end

endmodule
